decode_stage_hz: RTL and testbench

- Parametrised RV32I/RV32E decode stage with its ID/EX pipeline register.
- Decodes the instruction, reads the register file with write-back bypass, generates immediates and carries the result into EX.
- Adds what the prior decode lacked: a valid bit, external stall (hold), flush (bubble), internal load-use detection with bubble insertion, and illegal-instruction flagging.
- Sits between the fetch pipeline register and the execute stage.

---
 rtl/decode_stage_hz_if.sv | 50 +++++
 rtl/decode_stage_hz.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_hz_if.sv
// Bundle of decode-stage signals between the fetch/write-back side and the
// decode stage with its ID/EX register.
interface decode_stage_hz_if #(
   parameter int XLEN = 32
);
   logic [31:0]      InstrD;
   logic [XLEN-1:0]  PCD;
   logic [XLEN-1:0]  PCPlus4D;
   logic             ValidD;
   logic             StallD;
   logic             FlushE;
   logic             RegWriteW;
   logic [4:0]       RDW;
   logic [XLEN-1:0]  ResultW;

   logic             LoadUseD;
   logic             IllegalD;
   logic             ValidE;
   logic             RegWriteE;
   logic             ALUSrcE;
   logic             MemWriteE;
   logic             BranchE;
   logic             JumpE;
   logic [1:0]       ResultSrcE;
   logic [2:0]       ALUControlE;
   logic [XLEN-1:0]  RD1E;
   logic [XLEN-1:0]  RD2E;
   logic [XLEN-1:0]  ImmExtE;
   logic [XLEN-1:0]  PCE;
   logic [XLEN-1:0]  PCPlus4E;
   logic [4:0]       RS1E;
   logic [4:0]       RS2E;
   logic [4:0]       RDE;

   modport master (
      output InstrD, PCD, PCPlus4D, ValidD, StallD, FlushE,
             RegWriteW, RDW, ResultW,
      input  LoadUseD, IllegalD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
             BranchE, JumpE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE,
             PCE, PCPlus4E, RS1E, RS2E, RDE
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, ValidD, StallD, FlushE,
             RegWriteW, RDW, ResultW,
      output LoadUseD, IllegalD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
             BranchE, JumpE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE,
             PCE, PCPlus4E, RS1E, RS2E, RDE
   );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32I/RV32E decode stage: decoder, bypassed register file, immediate
// generation, load-use/illegal detection and the ID/EX pipeline register.
module decode_stage_hz #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              rst,
   decode_stage_hz_if.slave  bus
);

   localparam int AW = $clog2(NREG);

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            alu_src;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic [1:0]      result_src;
      logic [2:0]      alu_ctl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } idex_t;

   function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
      imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
      imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
      imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
      imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   function automatic logic [2:0] alu_op(input logic [2:0] f3,
                                         input logic       is_r,
                                         input logic       f7b5);
      case (f3)
         3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_op = ALU_SLT;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   endfunction

   function automatic logic reg_ok(input logic [4:0] r);
      reg_ok = (int'({27'd0, r}) < NREG);
   endfunction

   logic [XLEN-1:0] rf_q [NREG];

   logic [6:0]      opcode_s;
   logic [4:0]      rd_s;
   logic [4:0]      rs1_s;
   logic [4:0]      rs2_s;
   logic [2:0]      funct3_s;
   logic            f7b5_s;

   logic            reg_write_s;
   logic            alu_src_s;
   logic            mem_write_s;
   logic            branch_s;
   logic            jump_s;
   logic [1:0]      result_src_s;
   logic [2:0]      alu_ctl_s;
   logic [XLEN-1:0] imm_sel_s;
   logic            known_s;
   logic            use_rs1_s;
   logic            use_rs2_s;
   logic            use_rd_s;
   logic            cmp_rs1_s;
   logic            cmp_rs2_s;

   logic            rf_we_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;
   logic            illegal_s;
   logic            load_use_s;

   idex_t           dec_s;
   idex_t           idex_d;
   idex_t           idex_q;

   assign opcode_s = bus.InstrD[6:0];
   assign rd_s     = bus.InstrD[11:7];
   assign funct3_s = bus.InstrD[14:12];
   assign rs1_s    = bus.InstrD[19:15];
   assign rs2_s    = bus.InstrD[24:20];
   assign f7b5_s   = bus.InstrD[30];

   assign rf_we_s = bus.RegWriteW && (bus.RDW != 5'd0) && reg_ok(bus.RDW);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we_s) begin
         rf_q[bus.RDW[AW-1:0]] <= bus.ResultW;
      end
   end

   // Same-cycle write-back is forwarded so decode never sees a stale value.
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
      if (a == 5'd0) begin
         rf_read = '0;
      end else if (bus.RegWriteW && (bus.RDW == a)) begin
         rf_read = bus.ResultW;
      end else if (reg_ok(a)) begin
         rf_read = rf_q[a[AW-1:0]];
      end else begin
         rf_read = '0;
      end
   endfunction

   always_comb begin
      rd1_s = rf_read(rs1_s);
      rd2_s = rf_read(rs2_s);
   end

   always_comb begin
      reg_write_s  = 1'b0;
      alu_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      branch_s     = 1'b0;
      jump_s       = 1'b0;
      result_src_s = 2'b00;
      alu_ctl_s    = ALU_ADD;
      imm_sel_s    = '0;
      known_s      = 1'b0;
      use_rs1_s    = 1'b0;
      use_rs2_s    = 1'b0;
      use_rd_s     = 1'b0;
      case (opcode_s)
         OP_LW: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            result_src_s = 2'b01;
            imm_sel_s    = imm_i(bus.InstrD);
            known_s      = 1'b1;
            use_rs1_s    = 1'b1;
            use_rd_s     = 1'b1;
         end
         OP_SW: begin
            alu_src_s    = 1'b1;
            mem_write_s  = 1'b1;
            imm_sel_s    = imm_s(bus.InstrD);
            known_s      = 1'b1;
            use_rs1_s    = 1'b1;
            use_rs2_s    = 1'b1;
         end
         OP_R: begin
            reg_write_s  = 1'b1;
            alu_ctl_s    = alu_op(funct3_s, 1'b1, f7b5_s);
            known_s      = 1'b1;
            use_rs1_s    = 1'b1;
            use_rs2_s    = 1'b1;
            use_rd_s     = 1'b1;
         end
         OP_I: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            alu_ctl_s    = alu_op(funct3_s, 1'b0, f7b5_s);
            imm_sel_s    = imm_i(bus.InstrD);
            known_s      = 1'b1;
            use_rs1_s    = 1'b1;
            use_rd_s     = 1'b1;
         end
         OP_B: begin
            branch_s     = 1'b1;
            alu_ctl_s    = ALU_SUB;
            imm_sel_s    = imm_b(bus.InstrD);
            known_s      = 1'b1;
            use_rs1_s    = 1'b1;
            use_rs2_s    = 1'b1;
         end
         OP_J: begin
            reg_write_s  = 1'b1;
            jump_s       = 1'b1;
            result_src_s = 2'b10;
            imm_sel_s    = imm_j(bus.InstrD);
            known_s      = 1'b1;
            use_rd_s     = 1'b1;
         end
         default: begin
            known_s      = 1'b0;
         end
      endcase
   end

   assign illegal_s = bus.ValidD &&
                      (!known_s ||
                       (use_rs1_s && !reg_ok(rs1_s)) ||
                       (use_rs2_s && !reg_ok(rs2_s)) ||
                       (use_rd_s  && !reg_ok(rd_s)));

   // rs1 compare deliberately covers every opcode except jal, even unknown ones.
   assign cmp_rs1_s = (opcode_s != OP_J);
   assign cmp_rs2_s = (opcode_s == OP_R) || (opcode_s == OP_SW) || (opcode_s == OP_B);

   assign load_use_s = idex_q.valid && (idex_q.result_src == 2'b01) &&
                       (idex_q.rd != 5'd0) && bus.ValidD &&
                       ((cmp_rs1_s && (rs1_s == idex_q.rd)) ||
                        (cmp_rs2_s && (rs2_s == idex_q.rd)));

   always_comb begin
      dec_s            = '0;
      dec_s.valid      = 1'b1;
      dec_s.reg_write  = reg_write_s;
      dec_s.alu_src    = alu_src_s;
      dec_s.mem_write  = mem_write_s;
      dec_s.branch     = branch_s;
      dec_s.jump       = jump_s;
      dec_s.result_src = result_src_s;
      dec_s.alu_ctl    = alu_ctl_s;
      dec_s.rd1        = rd1_s;
      dec_s.rd2        = rd2_s;
      dec_s.imm        = imm_sel_s;
      dec_s.pc         = bus.PCD;
      dec_s.pc_plus4   = bus.PCPlus4D;
      dec_s.rs1        = use_rs1_s ? rs1_s : 5'd0;
      dec_s.rs2        = use_rs2_s ? rs2_s : 5'd0;
      dec_s.rd         = use_rd_s  ? rd_s  : 5'd0;
   end

   // Flush outranks stall so a killed instruction never lingers in EX.
   always_comb begin
      if (bus.FlushE) begin
         idex_d = '0;
      end else if (bus.StallD) begin
         idex_d = idex_q;
      end else if (load_use_s || !bus.ValidD || illegal_s) begin
         idex_d = '0;
      end else begin
         idex_d = dec_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign bus.LoadUseD    = load_use_s;
   assign bus.IllegalD    = illegal_s;
   assign bus.ValidE      = idex_q.valid;
   assign bus.RegWriteE   = idex_q.reg_write;
   assign bus.ALUSrcE     = idex_q.alu_src;
   assign bus.MemWriteE   = idex_q.mem_write;
   assign bus.BranchE     = idex_q.branch;
   assign bus.JumpE       = idex_q.jump;
   assign bus.ResultSrcE  = idex_q.result_src;
   assign bus.ALUControlE = idex_q.alu_ctl;
   assign bus.RD1E        = idex_q.rd1;
   assign bus.RD2E        = idex_q.rd2;
   assign bus.ImmExtE     = idex_q.imm;
   assign bus.PCE         = idex_q.pc;
   assign bus.PCPlus4E    = idex_q.pc_plus4;
   assign bus.RS1E        = idex_q.rs1;
   assign bus.RS2E        = idex_q.rs2;
   assign bus.RDE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: an RV32I instance carries the main
// vectors, an RV32E instance shares its inputs for the register-range cases.
module tb_decode_stage_hz;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   decode_stage_hz_if #(.XLEN(32)) bus32 ();
   decode_stage_hz_if #(.XLEN(32)) bus16 ();

   assign bus16.InstrD    = bus32.InstrD;
   assign bus16.PCD       = bus32.PCD;
   assign bus16.PCPlus4D  = bus32.PCPlus4D;
   assign bus16.ValidD    = bus32.ValidD;
   assign bus16.StallD    = bus32.StallD;
   assign bus16.FlushE    = bus32.FlushE;
   assign bus16.RegWriteW = bus32.RegWriteW;
   assign bus16.RDW       = bus32.RDW;
   assign bus16.ResultW   = bus32.ResultW;

   decode_stage_hz #(.XLEN(32), .NREG(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   decode_stage_hz #(.XLEN(32), .NREG(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ill;
      logic [10:0] ctl;   // {valid,regwrite,alusrc,memwrite,branch,jump,resultsrc,aluctl}
      logic [31:0] imm;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v, input logic [31:0] pc);
      bus32.InstrD   = ins;
      bus32.ValidD   = v;
      bus32.PCD      = pc;
      bus32.PCPlus4D = pc + 32'd4;
   endtask

   function automatic logic [10:0] ctl32();
      ctl32 = {bus32.ValidE, bus32.RegWriteE, bus32.ALUSrcE, bus32.MemWriteE,
               bus32.BranchE, bus32.JumpE, bus32.ResultSrcE, bus32.ALUControlE};
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0]  = '{32'h00018233, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 11'b11000000000, 32'h0,        32'hDEADBEEF, 32'h0,        5'd3, 5'd0, 5'd4};
      vecs[1]  = '{32'h404182B3, 1'b1, 1'b1, 5'd4, 32'h00000010, 1'b0, 11'b11000000001, 32'h0,        32'hDEADBEEF, 32'h00000010, 5'd3, 5'd4, 5'd5};
      vecs[2]  = '{32'h00407333, 1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 11'b11000000010, 32'h0,        32'h0,        32'h00000010, 5'd0, 5'd4, 5'd6};
      vecs[3]  = '{32'h003063B3, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b11000000011, 32'h0,        32'h0,        32'hDEADBEEF, 5'd0, 5'd3, 5'd7};
      vecs[4]  = '{32'hFFF22413, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b11100000101, 32'hFFFFFFFF, 32'h00000010, 32'h0,        5'd4, 5'd0, 5'd8};
      vecs[5]  = '{32'hFE322E23, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b10110000000, 32'hFFFFFFFC, 32'h00000010, 32'hDEADBEEF, 5'd4, 5'd3, 5'd0};
      vecs[6]  = '{32'hFE000CE3, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b10001000001, 32'hFFFFFFF8, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0};
      vecs[7]  = '{32'h001000EF, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b11000110000, 32'h00000800, 32'h0,        32'h0,        5'd0, 5'd0, 5'd1};
      vecs[8]  = '{32'h00018233, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 11'b00000000000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 5'd0};
      vecs[9]  = '{32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 11'b00000000000, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 5'd0};
      vecs[10] = '{32'h40000493, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b11100000000, 32'h00000400, 32'h0,        32'h0,        5'd0, 5'd0, 5'd9};
      vecs[11] = '{32'h0000A283, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 11'b11100001000, 32'h0,        32'h0,        32'h0,        5'd1, 5'd0, 5'd5};

      // Reset: outputs stay zero while rst is low, then addi x1,x0,5 lands.
      rst             = 1'b0;
      bus32.StallD    = 1'b0;
      bus32.FlushE    = 1'b0;
      bus32.RegWriteW = 1'b0;
      bus32.RDW       = 5'd0;
      bus32.ResultW   = 32'd0;
      drive(32'h00500093, 1'b1, 32'h00000040);
      #2;
      chk("rst_ctl", 64'(ctl32()), 64'd0);
      chk("rst_imm", 64'(bus32.ImmExtE), 64'd0);
      step();
      chk("rst_ctl_edge", 64'(ctl32()), 64'd0);
      chk("rst_pc", 64'(bus32.PCE), 64'd0);
      chk("rst_rd", 64'({bus32.RS1E, bus32.RS2E, bus32.RDE}), 64'd0);
      chk("rst_data", 64'({bus32.RD1E, bus32.RD2E}), 64'd0);
      rst = 1'b1;
      step();
      chk("addi_ctl", 64'(ctl32()), 64'(11'b11100000000));
      chk("addi_imm", 64'(bus32.ImmExtE), 64'd5);
      chk("addi_rd", 64'(bus32.RDE), 64'd1);
      chk("addi_pc4", 64'(bus32.PCPlus4E), 64'h44);

      for (int i = 0; i < 12; i++) begin
         logic [31:0] pc;
         pc = 32'h00001000 + 32'(i * 4);
         drive(vecs[i].instr, vecs[i].valid, pc);
         bus32.RegWriteW = vecs[i].wen;
         bus32.RDW       = vecs[i].wa;
         bus32.ResultW   = vecs[i].wd;
         #1;
         chk($sformatf("v%0d_illegal", i), 64'(bus32.IllegalD), 64'(vecs[i].ill));
         chk($sformatf("v%0d_loaduse", i), 64'(bus32.LoadUseD), 64'd0);
         step();
         chk($sformatf("v%0d_ctl", i), 64'(ctl32()), 64'(vecs[i].ctl));
         chk($sformatf("v%0d_imm", i), 64'(bus32.ImmExtE), 64'(vecs[i].imm));
         chk($sformatf("v%0d_rd1", i), 64'(bus32.RD1E), 64'(vecs[i].rd1));
         chk($sformatf("v%0d_rd2", i), 64'(bus32.RD2E), 64'(vecs[i].rd2));
         chk($sformatf("v%0d_rs1", i), 64'(bus32.RS1E), 64'(vecs[i].rs1));
         chk($sformatf("v%0d_rs2", i), 64'(bus32.RS2E), 64'(vecs[i].rs2));
         chk($sformatf("v%0d_rde", i), 64'(bus32.RDE), 64'(vecs[i].rd));
         chk($sformatf("v%0d_pc", i), 64'(bus32.PCE), vecs[i].ctl[10] ? 64'(pc) : 64'd0);
         chk($sformatf("v%0d_pc4", i), 64'(bus32.PCPlus4E), vecs[i].ctl[10] ? 64'(pc + 32'd4) : 64'd0);
      end
      bus32.RegWriteW = 1'b0;
      bus32.RDW       = 5'd0;
      bus32.ResultW   = 32'd0;

      // Load-use: lw x5 in EX, add x6,x5,x2 in decode.
      drive(32'h00228333, 1'b1, 32'h00002000);
      #1;
      chk("lu_detect", 64'(bus32.LoadUseD), 64'd1);
      step();
      chk("lu_bubble_valid", 64'(bus32.ValidE), 64'd0);
      chk("lu_bubble_rw", 64'(bus32.RegWriteE), 64'd0);
      chk("lu_clear", 64'(bus32.LoadUseD), 64'd0);
      step();
      chk("lu_enter_valid", 64'(bus32.ValidE), 64'd1);
      chk("lu_enter_rs", 64'({bus32.RS1E, bus32.RS2E, bus32.RDE}), 64'({5'd5, 5'd2, 5'd6}));
      drive(32'h0000A283, 1'b1, 32'h00002004);
      step();
      drive(32'h00500393, 1'b1, 32'h00002008);
      #1;
      chk("lu_itype_rs2", 64'(bus32.LoadUseD), 64'd0);
      step();

      // Flush beats stall; then stall alone holds EX for three cycles.
      drive(32'h00018233, 1'b1, 32'h00003000);
      step();
      bus32.FlushE = 1'b1;
      bus32.StallD = 1'b1;
      step();
      chk("flush_valid", 64'(bus32.ValidE), 64'd0);
      chk("flush_rw", 64'(bus32.RegWriteE), 64'd0);
      bus32.FlushE = 1'b0;
      bus32.StallD = 1'b0;
      drive(32'h404182B3, 1'b1, 32'h00003010);
      step();
      bus32.StallD = 1'b1;
      drive(32'h001000EF, 1'b1, 32'h00003014);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("stall%0d_ctl", c), 64'(ctl32()), 64'(11'b11000000001));
         chk($sformatf("stall%0d_rde", c), 64'(bus32.RDE), 64'd5);
         chk($sformatf("stall%0d_data", c), 64'({bus32.RD1E, bus32.RD2E}), {32'hDEADBEEF, 32'h00000010});
         chk($sformatf("stall%0d_pc", c), 64'(bus32.PCE), 64'h3010);
      end

      // Mid-operation reset clears EX at once and empties the register file.
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ctl", 64'(ctl32()), 64'd0);
      chk("midrst_data", 64'({bus32.RD1E, bus32.RD2E}), 64'd0);
      step();
      rst = 1'b1;
      bus32.StallD = 1'b0;
      drive(32'h00018233, 1'b1, 32'h00004000);
      step();
      chk("midrst_valid", 64'(bus32.ValidE), 64'd1);
      chk("midrst_rf", 64'(bus32.RD1E), 64'd0);

      // RV32E range check: x17 is illegal only on the 16-register instance.
      drive(32'h002088B3, 1'b1, 32'h00005000);
      #1;
      chk("e_ill16", 64'(bus16.IllegalD), 64'd1);
      chk("e_ill32", 64'(bus32.IllegalD), 64'd0);
      step();
      chk("e_bubble16", 64'(bus16.ValidE), 64'd0);
      chk("e_valid32", 64'(bus32.ValidE), 64'd1);
      chk("e_rde32", 64'(bus32.RDE), 64'd17);
      drive(32'h00018233, 1'b1, 32'h00005004);
      #1;
      chk("e_legal16", 64'(bus16.IllegalD), 64'd0);
      drive(32'h0000007F, 1'b1, 32'h00005008);
      #1;
      chk("e_op7f16", 64'(bus16.IllegalD), 64'd1);
      step();
      chk("e_op7f_bubble", 64'(bus16.ValidE), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
